// File: rtl/bm_pkg.sv
// Shared block-minifloat helpers: word sizes, product-word field positions and
// representable exponent limits. Used by both the BM multiplier and normalizer.
package bm_pkg;

  function automatic int bm_size(input int e, input int m);
    return 1 + e + m;
  endfunction

  function automatic int p_size(input int e, input int m);
    return 2*m + e + 4;
  endfunction

  // Product word layout: {sign, exp[e:0], man[2m+1:0]}
  function automatic int p_sign_pos(input int e, input int m);
    return p_size(e, m) - 1;
  endfunction

  function automatic int p_exp_lsb(input int m);
    return 2*m + 2;
  endfunction

  function automatic int exp_max(input int e);
    return (1 << (e-1)) - 1;
  endfunction

  function automatic int exp_min(input int e);
    return -(1 << (e-1));
  endfunction

endpackage

// File: rtl/bm_round_rne.sv
// Normalizes a 2m+2 bit product mantissa and rounds it to m bits, nearest-even.
// rc flags a carry out of the kept field, which then reads as zero.
module bm_round_rne #(
  parameter int m = 4
) (
  input  logic [2*m+1:0] man,
  output logic [m-1:0]   keep,
  output logic           norm,
  output logic           rc
);

  logic [2*m-1:0] frac;
  logic           guard, sticky, rnd;
  logic [m:0]     sum;

  always_comb begin
    norm   = man[2*m+1];
    // Product in [2,4): one extra bit shifts out and joins the sticky
    frac   = norm ? man[2*m:1] : man[2*m-1:0];
    guard  = frac[m-1];
    sticky = (|frac[m-2:0]) | (norm & man[0]);
    rnd    = guard & (sticky | frac[m]);
    sum    = {1'b0, frac[2*m-1:m]} + {{m{1'b0}}, rnd};
    keep   = sum[m-1:0];
    rc     = sum[m];
  end

endmodule

// File: rtl/bm_product_normalizer.sv
// Two-stage valid/ready pipeline turning a wide BM product back into BM storage
// format: normalize + RNE in stage 1, re-bias + saturate in stage 2.
module bm_product_normalizer
  import bm_pkg::*;
#(
  parameter  int e          = 3,
  parameter  int m          = 4,
  parameter  int sb_size    = 3,
  parameter  int EXP_OFFSET = 2,
  parameter  int CNT_W      = 16,
  localparam int BM_size    = bm_size(e, m),
  localparam int P_size     = p_size(e, m)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_size-1:0]  in_prod,
  input  logic               in_exp_ovf,
  input  logic [sb_size-1:0] in_sb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BM_size-1:0] out_bm,
  output logic [sb_size-1:0] out_sb,
  output logic               out_ovf,
  output logic               out_unf,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   sat_count,
  output logic [CNT_W-1:0]   unf_count
);

  localparam int SGN = p_sign_pos(e, m);
  localparam int EXL = p_exp_lsb(m);
  localparam logic signed [e+1:0] XMAX = (e+2)'(exp_max(e));
  localparam logic signed [e+1:0] XMIN = (e+2)'(exp_min(e));
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  logic [2:1] vld_pipe;
  logic       s1_load, s2_load;

  logic               s1_sign, s1_eovf, s1_norm, s1_rc;
  logic [e:0]         s1_exp;
  logic [m-1:0]       s1_keep;
  logic [sb_size-1:0] s1_sb;

  logic [m-1:0] rn_keep;
  logic         rn_norm, rn_rc;

  logic signed [e+1:0] xe;
  logic [BM_size-1:0]  s2_bm;
  logic                s2_ovf, s2_unf;

  bm_round_rne #(.m(m)) u_rne (
    .man  (in_prod[2*m+1:0]),
    .keep (rn_keep),
    .norm (rn_norm),
    .rc   (rn_rc)
  );

  assign s2_load   = vld_pipe[1] & (!vld_pipe[2] | out_ready);
  assign in_ready  = !vld_pipe[1] | !vld_pipe[2] | out_ready;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = vld_pipe[2];

  // e+2 bits holds every exp - offset + 2 without wrapping
  always_comb begin
    xe     = $signed({s1_exp[e], s1_exp}) - (e+2)'(EXP_OFFSET)
             + (e+2)'(s1_norm) + (e+2)'(s1_rc);
    s2_ovf = 1'b0;
    s2_unf = 1'b0;
    s2_bm  = {s1_sign, xe[e-1:0], s1_keep};
    if (s1_eovf || xe > XMAX) begin
      s2_bm  = {s1_sign, XMAX[e-1:0], {m{1'b1}}};
      s2_ovf = 1'b1;
    end else if (xe < XMIN) begin
      s2_bm  = {s1_sign, XMIN[e-1:0], {m{1'b0}}};
      s2_unf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_sign  <= 1'b0;
      s1_eovf  <= 1'b0;
      s1_norm  <= 1'b0;
      s1_rc    <= 1'b0;
      s1_exp   <= '0;
      s1_keep  <= '0;
      s1_sb    <= '0;
      out_bm   <= '0;
      out_sb   <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= 1'b1;
        s1_sign     <= in_prod[SGN];
        s1_exp      <= in_prod[EXL +: e+1];
        s1_eovf     <= in_exp_ovf;
        s1_sb       <= in_sb;
        s1_keep     <= rn_keep;
        s1_norm     <= rn_norm;
        s1_rc       <= rn_rc;
      end else if (s2_load) begin
        vld_pipe[1] <= 1'b0;
      end
      if (s2_load) begin
        vld_pipe[2] <= 1'b1;
        out_bm      <= s2_bm;
        out_sb      <= s1_sb;
        out_ovf     <= s2_ovf;
        out_unf     <= s2_unf;
      end else if (out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  // Event counters: clear wins over increment, both stick at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      sat_count <= '0;
      unf_count <= '0;
    end else if (out_valid && out_ready) begin
      if (out_ovf && sat_count != CNT_MAX) sat_count <= sat_count + 1'b1;
      if (out_unf && unf_count != CNT_MAX) unf_count <= unf_count + 1'b1;
    end
  end

endmodule
